// File: rtl/besdpb_arbiter.sv
// Round-robin arbiter sharing one byte-enabled single-port RAM between a
// read-only fetch port (A) and a read/write data port (B).
module besdpb_arbiter #(
  parameter int ADDRESS_BITWIDTH = 16,
  parameter int DATA_BITWIDTH    = 32,
  parameter int COLUMN_BITWIDTH  = 8,
  parameter int COLUMN_COUNT     = DATA_BITWIDTH / COLUMN_BITWIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        a_req,
  input  logic [ADDRESS_BITWIDTH-1:0] a_address,
  output logic                        a_ready,
  output logic                        a_done,
  output logic [DATA_BITWIDTH-1:0]    a_rdata,
  input  logic                        b_req,
  input  logic [COLUMN_COUNT-1:0]     b_write_enable,
  input  logic [ADDRESS_BITWIDTH-1:0] b_address,
  input  logic [DATA_BITWIDTH-1:0]    b_data_in,
  output logic                        b_ready,
  output logic                        b_done,
  output logic [DATA_BITWIDTH-1:0]    b_rdata,
  output logic [COLUMN_COUNT-1:0]     ram_write_enable,
  output logic [ADDRESS_BITWIDTH-1:0] ram_address,
  output logic [DATA_BITWIDTH-1:0]    ram_data_in,
  input  logic [DATA_BITWIDTH-1:0]    ram_data_out
);

  // 1 = B was the most recently accepted port; reset so A wins the first tie
  logic last_grant_b;
  logic b_is_read;

  assign a_ready   = a_req & (~b_req | last_grant_b);
  assign b_ready   = b_req & (~a_req | ~last_grant_b);
  assign b_is_read = ~(|b_write_enable);

  always_comb begin
    ram_address      = '0;
    ram_write_enable = '0;
    if (a_ready) begin
      ram_address = a_address;
    end else if (b_ready) begin
      ram_address      = b_address;
      ram_write_enable = b_write_enable;
    end
  end

  assign ram_data_in = b_data_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_b <= 1'b1;
      a_done       <= 1'b0;
      b_done       <= 1'b0;
      a_rdata      <= '0;
      b_rdata      <= '0;
    end else begin
      a_done <= a_ready;
      b_done <= b_ready;
      if (a_ready || b_ready) begin
        last_grant_b <= b_ready;
      end
      if (a_ready) begin
        a_rdata <= ram_data_out;
      end
      // writes complete with a done pulse but leave the read data untouched
      if (b_ready && b_is_read) begin
        b_rdata <= ram_data_out;
      end
    end
  end

endmodule

// File: tb/tb_besdpb_arbiter.sv
// Directed bench for besdpb_arbiter with a behavioural byte-masked RAM model.
module tb_besdpb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        a_req;
  logic [15:0] a_address;
  logic        a_ready;
  logic        a_done;
  logic [31:0] a_rdata;
  logic        b_req;
  logic [3:0]  b_write_enable;
  logic [15:0] b_address;
  logic [31:0] b_data_in;
  logic        b_ready;
  logic        b_done;
  logic [31:0] b_rdata;
  logic [3:0]  ram_write_enable;
  logic [15:0] ram_address;
  logic [31:0] ram_data_in;
  logic [31:0] ram_data_out;

  logic [31:0] mem [0:255];
  int checks;
  int errors;

  besdpb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_address(a_address), .a_ready(a_ready),
    .a_done(a_done), .a_rdata(a_rdata),
    .b_req(b_req), .b_write_enable(b_write_enable), .b_address(b_address),
    .b_data_in(b_data_in), .b_ready(b_ready), .b_done(b_done), .b_rdata(b_rdata),
    .ram_write_enable(ram_write_enable), .ram_address(ram_address),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ram_data_out = mem[ram_address[7:0]];

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ram_write_enable[i]) mem[ram_address[7:0]][8*i +: 8] <= ram_data_in[8*i +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_a;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h10] = 32'hDEADBEEF;
    mem[8'h20] = 32'hAABBCCDD;
    mem[8'h40] = 32'hCAFEF00D;
    rst_n = 1'b0;
    a_req = 1'b0; a_address = '0;
    b_req = 1'b0; b_write_enable = '0; b_address = '0; b_data_in = '0;
    #2;
    check("rst_a_done", 32'(a_done), 32'h0);
    check("rst_b_done", 32'(b_done), 32'h0);
    check("rst_a_rdata", a_rdata, 32'h0);
    check("rst_b_rdata", b_rdata, 32'h0);
    #10 rst_n = 1'b1;

    // 1: A alone
    a_req = 1'b1; a_address = 16'h0010;
    #1;
    check("t1_a_ready", 32'(a_ready), 32'h1);
    check("t1_b_ready", 32'(b_ready), 32'h0);
    check("t1_ram_addr", 32'(ram_address), 32'h10);
    check("t1_ram_we", 32'(ram_write_enable), 32'h0);
    step();
    a_req = 1'b0;
    check("t1_a_done", 32'(a_done), 32'h1);
    check("t1_a_rdata", a_rdata, 32'hDEADBEEF);
    check("t1_b_done", 32'(b_done), 32'h0);
    step();
    check("t1_a_done_pulse", 32'(a_done), 32'h0);
    check("t1_a_rdata_hold", a_rdata, 32'hDEADBEEF);

    // 2: B partial write then read-back
    b_req = 1'b1; b_write_enable = 4'b0011; b_address = 16'h0020; b_data_in = 32'h12345678;
    #1;
    check("t2_b_ready", 32'(b_ready), 32'h1);
    check("t2_ram_we", 32'(ram_write_enable), 32'h3);
    step();
    check("t2_wr_done", 32'(b_done), 32'h1);
    check("t2_wr_rdata", b_rdata, 32'h0);
    check("t2_mem", mem[8'h20], 32'hAABB5678);
    b_write_enable = 4'b0000;
    step();
    b_req = 1'b0;
    check("t2_rd_done", 32'(b_done), 32'h1);
    check("t2_rd_rdata", b_rdata, 32'hAABB5678);

    // 3: both held, strict alternation starting with A
    a_req = 1'b1; a_address = 16'h0010;
    b_req = 1'b1; b_address = 16'h0020;
    for (int i = 0; i < 6; i++) begin
      exp_a = (i % 2 == 0);
      #1;
      check("t3_a_ready", 32'(a_ready), 32'(exp_a));
      check("t3_b_ready", 32'(b_ready), 32'(!exp_a));
      step();
      check("t3_a_done", 32'(a_done), 32'(exp_a));
      check("t3_b_done", 32'(b_done), 32'(!exp_a));
    end
    check("t3_a_rdata", a_rdata, 32'hDEADBEEF);
    check("t3_b_rdata", b_rdata, 32'hAABB5678);

    // 4: tie after B, B solo twice, tie again
    #1;
    check("t4_tie1_a", 32'(a_ready), 32'h1);
    step();
    a_req = 1'b0;
    #1;
    check("t4_solo1_b", 32'(b_ready), 32'h1);
    step();
    check("t4_solo1_done", 32'(b_done), 32'h1);
    check("t4_solo2_b", 32'(b_ready), 32'h1);
    step();
    check("t4_solo2_done", 32'(b_done), 32'h1);
    a_req = 1'b1;
    #1;
    check("t4_tie2_a", 32'(a_ready), 32'h1);
    check("t4_tie2_b", 32'(b_ready), 32'h0);
    step();
    a_req = 1'b0;
    check("t4_tie2_done", 32'(a_done), 32'h1);

    // 5: async reset while a B write is granted
    b_req = 1'b1; b_write_enable = 4'hF; b_address = 16'h0030; b_data_in = 32'h55AA55AA;
    #1;
    check("t5_b_ready", 32'(b_ready), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("t5_a_done", 32'(a_done), 32'h0);
    check("t5_b_done", 32'(b_done), 32'h0);
    check("t5_a_rdata", a_rdata, 32'h0);
    check("t5_b_rdata", b_rdata, 32'h0);
    b_req = 1'b0; b_write_enable = 4'h0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    a_req = 1'b1; a_address = 16'h0010;
    b_req = 1'b1; b_address = 16'h0020;
    #1;
    check("t5_tie_a", 32'(a_ready), 32'h1);
    check("t5_tie_b", 32'(b_ready), 32'h0);
    step();
    check("t5_a_done2", 32'(a_done), 32'h1);
    check("t5_a_rdata2", a_rdata, 32'hDEADBEEF);

    // 6: A pulses one cycle while B holds the grant -> withdrawn
    a_address = 16'h0040;
    #1;
    check("t6_b_ready", 32'(b_ready), 32'h1);
    check("t6_a_ready", 32'(a_ready), 32'h0);
    step();
    a_req = 1'b0;
    check("t6_a_done", 32'(a_done), 32'h0);
    check("t6_b_done", 32'(b_done), 32'h1);
    b_req = 1'b0;
    step();
    check("t6_a_done2", 32'(a_done), 32'h0);
    check("t6_a_rdata", a_rdata, 32'hDEADBEEF);
    check("t6_mem40", mem[8'h40], 32'hCAFEF00D);
    check("t6_idle_addr", 32'(ram_address), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
